// File: rtl/smart_lock_pkg.sv
// Shared types and sizing helpers for the multi-digit PIN lock controller.
package smart_lock_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_CHG_NEW,
        ST_CHG_CONF,
        ST_LOCKOUT
    } state_t;

    localparam int unsigned DEF_DIGIT_W    = 4;
    localparam int unsigned DEF_NUM_DIGITS = 4;
    localparam int unsigned PIN_W          = DEF_DIGIT_W * DEF_NUM_DIGITS;
    localparam logic [PIN_W-1:0] DEF_PIN   = 16'h1234;

    // Bits needed to hold values 0..n (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; expired_c pulses on the last counted cycle after a load.
module lock_timer #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired_c
);

    logic [W-1:0] count;
    logic         running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= value;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - W'(1);
            end
        end
    end

    assign expired_c = running && (count == '0);

endmodule

// File: rtl/smart_lock_ctrl.sv
// Multi-digit PIN lock: entry check, timed unlock, PIN change with confirmation,
// timed lockout after repeated failures and a sticky alarm on repeated lockouts.
module smart_lock_ctrl
    import smart_lock_pkg::*;
#(
    parameter int unsigned DIGIT_W        = DEF_DIGIT_W,
    parameter int unsigned NUM_DIGITS     = DEF_NUM_DIGITS,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000000,
    parameter int unsigned UNLOCK_CYCLES  = 500000,
    parameter int unsigned ALARM_LOCKOUTS = 2,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_PIN = DEF_PIN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              digit_vld,
    input  logic                              enter,
    input  logic                              clear,
    input  logic                              chg_req,
    output logic                              unlocked,
    output logic                              chg_mode,
    output logic                              lockout,
    output logic                              alarm,
    output logic                              chg_done,
    output logic                              chg_err,
    output logic [$clog2(MAX_TRIES+1)-1:0]    fail_cnt,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_cnt
);

    localparam int unsigned PW = DIGIT_W * NUM_DIGITS;
    localparam int unsigned FW = $clog2(MAX_TRIES + 1);
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
    localparam int unsigned SW = cnt_w(ALARM_LOCKOUTS);
    localparam int unsigned TW = cnt_w(max_u(LOCKOUT_CYCLES, UNLOCK_CYCLES));

    state_t          state, state_n;
    logic [PW-1:0]   pin_q, buf_q, cand_q;
    logic [SW-1:0]   streak;
    logic            match_q;
    logic            full_c, tmr_exp_c;
    logic            buf_clr, buf_shift, chk_latch, cand_ld, pin_st;
    logic            fail_inc, fail_clr, streak_inc, streak_clr;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            unlocked_n, chg_mode_n, lockout_n, chg_done_n, chg_err_n;

    assign full_c = (entry_cnt == CW'(NUM_DIGITS));

    lock_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .value     (tmr_val),
        .expired_c (tmr_exp_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ENTRY;
        else     state <= state_n;
    end

    // Next state and datapath controls; clear > enter > digit inside the buffer states.
    always_comb begin
        state_n    = state;
        buf_clr    = 1'b0;
        buf_shift  = 1'b0;
        chk_latch  = 1'b0;
        cand_ld    = 1'b0;
        pin_st     = 1'b0;
        fail_inc   = 1'b0;
        fail_clr   = 1'b0;
        streak_inc = 1'b0;
        streak_clr = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        chg_done_n = 1'b0;
        chg_err_n  = 1'b0;
        unique case (state)
            ST_ENTRY: begin
                if (clear) begin
                    buf_clr = 1'b1;
                end else if (enter) begin
                    buf_clr   = 1'b1;
                    chk_latch = 1'b1;
                    state_n   = ST_CHECK;
                end else if (digit_vld && !full_c) begin
                    buf_shift = 1'b1;
                end
            end
            ST_CHECK: begin
                tmr_load = 1'b1;
                if (match_q) begin
                    fail_clr   = 1'b1;
                    streak_clr = 1'b1;
                    tmr_val    = TW'(UNLOCK_CYCLES - 1);
                    state_n    = ST_OPEN;
                end else if (fail_cnt == FW'(MAX_TRIES - 1)) begin
                    fail_inc   = 1'b1;
                    streak_inc = 1'b1;
                    tmr_val    = TW'(LOCKOUT_CYCLES - 1);
                    state_n    = ST_LOCKOUT;
                end else begin
                    fail_inc = 1'b1;
                    state_n  = ST_ENTRY;
                end
            end
            ST_OPEN: begin
                if (enter)          state_n = ST_ENTRY;
                else if (chg_req)   state_n = ST_CHG_NEW;
                else if (tmr_exp_c) state_n = ST_ENTRY;
            end
            ST_CHG_NEW: begin
                if (clear) begin
                    buf_clr = 1'b1;
                    state_n = ST_ENTRY;
                end else if (enter) begin
                    buf_clr = 1'b1;
                    cand_ld = full_c;
                    state_n = full_c ? ST_CHG_CONF : ST_ENTRY;
                end else if (digit_vld && !full_c) begin
                    buf_shift = 1'b1;
                end
            end
            ST_CHG_CONF: begin
                if (clear) begin
                    buf_clr = 1'b1;
                    state_n = ST_ENTRY;
                end else if (enter) begin
                    buf_clr = 1'b1;
                    state_n = ST_ENTRY;
                    if (full_c && (buf_q == cand_q)) begin
                        pin_st     = 1'b1;
                        chg_done_n = 1'b1;
                    end else begin
                        chg_err_n = 1'b1;
                    end
                end else if (digit_vld && !full_c) begin
                    buf_shift = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_exp_c) begin
                    fail_clr = 1'b1;
                    state_n  = ST_ENTRY;
                end
            end
            default: state_n = ST_ENTRY;
        endcase
        unlocked_n = (state_n == ST_OPEN);
        chg_mode_n = (state_n == ST_CHG_NEW) || (state_n == ST_CHG_CONF);
        lockout_n  = (state_n == ST_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_q     <= DEFAULT_PIN;
            buf_q     <= '0;
            cand_q    <= '0;
            entry_cnt <= '0;
            match_q   <= 1'b0;
            fail_cnt  <= '0;
            streak    <= '0;
            alarm     <= 1'b0;
            unlocked  <= 1'b0;
            chg_mode  <= 1'b0;
            lockout   <= 1'b0;
            chg_done  <= 1'b0;
            chg_err   <= 1'b0;
        end else begin
            unlocked <= unlocked_n;
            chg_mode <= chg_mode_n;
            lockout  <= lockout_n;
            chg_done <= chg_done_n;
            chg_err  <= chg_err_n;
            if (buf_clr) begin
                buf_q     <= '0;
                entry_cnt <= '0;
            end else if (buf_shift) begin
                buf_q     <= (buf_q << DIGIT_W) | PW'(digit_in);
                entry_cnt <= entry_cnt + CW'(1);
            end
            // Compare is captured at enter because the buffer is cleared on the same edge.
            if (chk_latch) match_q <= full_c && (buf_q == pin_q);
            if (cand_ld)   cand_q  <= buf_q;
            if (pin_st)    pin_q   <= cand_q;
            if (fail_clr)      fail_cnt <= '0;
            else if (fail_inc) fail_cnt <= fail_cnt + FW'(1);
            if (streak_clr) begin
                streak <= '0;
            end else if (streak_inc && (streak != SW'(ALARM_LOCKOUTS))) begin
                streak <= streak + SW'(1);
            end
            if (streak_inc && (streak >= SW'(ALARM_LOCKOUTS - 1))) alarm <= 1'b1;
        end
    end

endmodule

// File: tb/tb_smart_lock_ctrl.sv
// Self-checking bench for smart_lock_ctrl: vector table, directed sequences and
// randomized traffic against an event-level behavioural model.
module tb_smart_lock_ctrl;

    localparam int unsigned DW = 4;
    localparam int unsigned ND = 4;
    localparam int unsigned MT = 3;
    localparam int unsigned UC = 4;
    localparam int unsigned LC = 8;
    localparam int unsigned AL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       digit_vld, enter, clear, chg_req;
    logic       unlocked, chg_mode, lockout, alarm, chg_done, chg_err;
    logic [1:0] fail_cnt;
    logic [2:0] entry_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    smart_lock_ctrl #(
        .DIGIT_W(DW), .NUM_DIGITS(ND), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC),
        .UNLOCK_CYCLES(UC), .ALARM_LOCKOUTS(AL), .DEFAULT_PIN(16'h1234)
    ) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .digit_vld(digit_vld),
        .enter(enter), .clear(clear), .chg_req(chg_req), .unlocked(unlocked),
        .chg_mode(chg_mode), .lockout(lockout), .alarm(alarm), .chg_done(chg_done),
        .chg_err(chg_err), .fail_cnt(fail_cnt), .entry_cnt(entry_cnt)
    );

    // Behavioural model: remaining-time counters, a digit queue and a change phase.
    int q[$];
    int m_pin, m_cand, m_phase, m_open, m_lock, m_fails, m_streak;
    bit m_alarm, m_done, m_err, m_chk, m_ok;

    function automatic void m_reset();
        q.delete();
        m_pin = 'h1234; m_cand = 0; m_phase = 0; m_open = 0; m_lock = 0;
        m_fails = 0; m_streak = 0; m_alarm = 0; m_done = 0; m_err = 0;
        m_chk = 0; m_ok = 0;
    endfunction

    function automatic int q_val();
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return v;
    endfunction

    function automatic void m_step(bit dv, int d, bit en, bit cl, bit cr);
        int v;
        bit full;
        m_done = 0;
        m_err  = 0;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (m_chk) begin
            m_chk = 0;
            if (m_ok) begin
                m_open = UC; m_fails = 0; m_streak = 0;
            end else begin
                m_fails++;
                if (m_fails == MT) begin
                    m_lock = LC;
                    m_streak++;
                    if (m_streak >= AL) m_alarm = 1;
                end
            end
        end else if (m_open > 0) begin
            if (en) m_open = 0;
            else if (cr) begin m_open = 0; m_phase = 1; end
            else m_open--;
        end else if (cl) begin
            q.delete();
            m_phase = 0;
        end else if (en) begin
            full = (q.size() == ND);
            v = q_val();
            q.delete();
            case (m_phase)
                0: begin m_chk = 1; m_ok = full && (v == m_pin); end
                1: begin
                    if (full) begin m_cand = v; m_phase = 2; end
                    else m_phase = 0;
                end
                default: begin
                    m_phase = 0;
                    if (full && v == m_cand) begin m_pin = v; m_done = 1; end
                    else m_err = 1;
                end
            endcase
        end else if (dv && q.size() < ND) begin
            q.push_back(d);
        end
    endfunction

    function automatic logic [12:0] m_out();
        return {m_open > 0, m_phase != 0, m_lock > 0, m_alarm, m_done, m_err,
                2'(m_fails), 3'(q.size())};
    endfunction

    function automatic logic [12:0] dut_out();
        return {unlocked, chg_mode, lockout, alarm, chg_done, chg_err, fail_cnt, entry_cnt};
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic dv, input logic [3:0] d, input logic en,
                        input logic cl, input logic cr);
        digit_in = d; digit_vld = dv; enter = en; clear = cl; chg_req = cr;
        m_step(dv, int'(d), en, cl, cr);
        @(posedge clk);
        #1;
        digit_vld = 1'b0; enter = 1'b0; clear = 1'b0; chg_req = 1'b0;
        check("cycle", 16'(dut_out()), 16'(m_out()));
    endtask

    task automatic key(input logic [3:0] d);
        tick(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ent();
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_pin(input logic [15:0] v);
        for (int i = 0; i < 4; i++) key(v[15-4*i -: 4]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        digit_in = 4'd0; digit_vld = 1'b0; enter = 1'b0; clear = 1'b0; chg_req = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset", 16'(dut_out()), 16'd0);
    endtask

    typedef struct {
        logic        dv;
        logic [3:0]  d;
        logic        en;
        logic [12:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic dv, input logic [3:0] d, input logic en,
                                input logic ul, input logic lk, input logic [1:0] fc,
                                input logic [2:0] ec);
        vec_t v;
        v.dv = dv; v.d = d; v.en = en;
        v.exp = {ul, 1'b0, lk, 1'b0, 1'b0, 1'b0, fc, ec};
        tbl.push_back(v);
    endfunction

    initial begin
        int idx, target;
        logic dv, en, cl, cr;
        logic [3:0] d;

        // Correct PIN with a fifth digit ignored, then the unlock window.
        add(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
        add(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
        add(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0, 3'd3);
        add(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4);
        add(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4);
        add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        for (int i = 0; i < 4; i++) add(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0);
        add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        // Three wrong entries, then the lockout window with ignored digits.
        for (int t = 0; t < 3; t++) begin
            add(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'(t), 3'd1);
            add(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2'(t), 3'd2);
            add(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 2'(t), 3'd3);
            add(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 2'(t), 3'd4);
            add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'(t), 3'd0);
            add(1'b0, 4'd0, 1'b0, 1'b0, t == 2, 2'(t + 1), 3'd0);
        end
        for (int i = 0; i < 7; i++) add(1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0);
        add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);

        do_reset();
        foreach (tbl[i]) begin
            tick(tbl[i].dv, tbl[i].d, tbl[i].en, 1'b0, 1'b0);
            check("vec", 16'(dut_out()), 16'(tbl[i].exp));
        end

        // Second lockout in a row raises alarm; it survives a later success.
        for (int t = 0; t < 3; t++) begin enter_pin(16'h1235); ent(); idle(1); end
        check("alarm_set", 16'({lockout, alarm}), 16'(2'b11));
        idle(8);
        check("lock_over", 16'({lockout, fail_cnt}), 16'd0);
        enter_pin(16'h1234); ent(); idle(1);
        check("alarm_sticky", 16'({unlocked, alarm}), 16'(2'b11));
        do_reset();

        // Successful PIN change.
        enter_pin(16'h1234); ent(); idle(1);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("chg_enter", 16'({unlocked, chg_mode}), 16'(2'b01));
        enter_pin(16'h9876); ent();
        enter_pin(16'h9876); ent();
        check("chg_done", 16'({chg_done, chg_err}), 16'(2'b10));
        enter_pin(16'h1234); ent(); idle(1);
        check("old_pin_fails", 16'({unlocked, fail_cnt}), 16'(3'b001));
        enter_pin(16'h9876); ent(); idle(1);
        check("new_pin_opens", 16'({unlocked, fail_cnt}), 16'(3'b100));
        ent();
        do_reset();

        // Confirmation mismatch keeps the old PIN; short entry counts as a failure.
        enter_pin(16'h1234); ent(); idle(1);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        enter_pin(16'h9876); ent();
        enter_pin(16'h9877); ent();
        check("chg_err", 16'({chg_err, chg_done}), 16'(2'b10));
        enter_pin(16'h1234); ent(); idle(1);
        check("pin_kept", 16'(unlocked), 16'd1);
        ent();
        key(4'd1); key(4'd2); ent(); idle(1);
        check("short_fail", 16'(fail_cnt), 16'd1);
        key(4'd1); key(4'd2);
        tick(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        check("clr_ent_buf", 16'(entry_cnt), 16'd0);
        idle(1);
        check("clr_ent_nofail", 16'(fail_cnt), 16'd1);

        // Asynchronous reset while open.
        enter_pin(16'h1234); ent(); idle(1);
        check("open_before_rst", 16'(unlocked), 16'd1);
        rst = 1'b1;
        #2;
        check("rst_open", 16'(dut_out()), 16'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic biased toward the PIN the model believes is stored.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                continue;
            end
            idx    = q.size();
            target = (m_phase == 2) ? m_cand : m_pin;
            if (m_phase != 1 && idx < 4 && $urandom_range(0, 3) != 0)
                d = 4'((target >> (12 - 4 * idx)) & 15);
            else
                d = 4'($urandom_range(0, 15));
            dv = ($urandom_range(0, 99) < 50);
            en = (idx == 4) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
            cl = ($urandom_range(0, 99) < 3);
            cr = ($urandom_range(0, 99) < 10);
            tick(dv, d, en, cl, cr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smart_lock_ctrl.md
Name: smart_lock_ctrl

Overview:
Parametrised multi-digit PIN lock controller, successor to the single-nibble lock FSM.
- Collects NUM_DIGITS keypad digits, checks them against a stored PIN, and grants timed unlock.
- Supports PIN change with confirmation, and a timed lockout after MAX_TRIES failures instead of a permanent one.
- Escalates to a sticky alarm after repeated lockouts.
- Sits behind the keypad/button debounce stage; all strobe inputs are already single-cycle, debounced, synchronous pulses.

Parameters:
DIGIT_W, 4, bits per digit
NUM_DIGITS, 4, digits per PIN
MAX_TRIES, 3, consecutive wrong entries before lockout (>=1)
LOCKOUT_CYCLES, 1000000, lockout duration in clk cycles
UNLOCK_CYCLES, 500000, unlock hold duration in clk cycles
ALARM_LOCKOUTS, 2, consecutive lockouts that raise alarm
DEFAULT_PIN, 16'h1234, PIN after reset, width DIGIT_W*NUM_DIGITS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
digit_in  in  DIGIT_W  keypad digit value
digit_vld  in  1  single-cycle strobe: digit_in valid
enter  in  1  single-cycle strobe: submit entry
clear  in  1  single-cycle strobe: clear entry / abort change
chg_req  in  1  single-cycle strobe: request PIN change (honoured only while unlocked)
unlocked  out  1  lock open
chg_mode  out  1  high in CHG_NEW/CHG_CONF
lockout  out  1  timed lockout active
alarm  out  1  sticky alarm
chg_done  out  1  one-cycle pulse: PIN updated
chg_err  out  1  one-cycle pulse: confirmation mismatch
fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures
entry_cnt  out  $clog2(NUM_DIGITS+1)  digits currently buffered

Behaviour:
- Reset: state ENTRY, stored PIN = DEFAULT_PIN, buffer/candidate = 0, all outputs 0, lockout streak = 0.
- States: ENTRY, CHECK, OPEN, CHG_NEW, CHG_CONF, LOCKOUT.
- Entry buffer, in ENTRY/CHG_NEW/CHG_CONF:
  - digit_vld shifts digit_in into the LSB digit and increments entry_cnt.
  - entry_cnt saturates at NUM_DIGITS; further digits are ignored.
  - clear empties the buffer.
- Input priority in the same cycle: clear > enter > digit_vld. A digit that coincides with enter is dropped.
- ENTRY:
  - enter with entry_cnt==NUM_DIGITS -> CHECK.
  - enter with a short entry -> counted as a failure, handled exactly like a mismatch.
  - The buffer is cleared on every enter.
- CHECK (1 cycle), on match:
  - -> OPEN; fail_cnt and lockout streak cleared.
  - Latency: enter accepted in cycle N; unlocked=1 from cycle N+2.
- CHECK (1 cycle), on mismatch:
  - fail_cnt+1.
  - If it reaches MAX_TRIES -> LOCKOUT and lockout streak+1; otherwise -> ENTRY.
- OPEN:
  - unlocked=1 for exactly UNLOCK_CYCLES, then -> ENTRY.
  - enter relocks immediately.
  - chg_req -> CHG_NEW; unlocked drops.
- CHG_NEW: enter with a full buffer latches the candidate -> CHG_CONF. A short enter or clear aborts to ENTRY; PIN unchanged.
- CHG_CONF, enter with a full buffer:
  - Equal to candidate -> stored PIN := candidate, chg_done pulse, -> ENTRY.
  - Otherwise -> chg_err pulse, -> ENTRY, PIN unchanged.
  - clear aborts to ENTRY.
- Change failures never increment fail_cnt.
- LOCKOUT:
  - lockout=1 for exactly LOCKOUT_CYCLES; all strobes ignored.
  - At expiry fail_cnt := 0, -> ENTRY.
  - When the streak reaches ALARM_LOCKOUTS, alarm := 1. alarm stays set until rst and does not block operation.
- chg_req outside OPEN: ignored.
- Timers: a single down-counter sized for max(LOCKOUT_CYCLES, UNLOCK_CYCLES), loaded on state entry.
- rst mid-operation: immediate return to reset values; a changed PIN reverts to DEFAULT_PIN.

Decomposition:
- Package smart_lock_pkg holds:
  - state enum.
  - PIN_W = DIGIT_W*NUM_DIGITS.
  - Counter-width localparams.
- One sub-module, lock_timer: loadable down-counter with load/value inputs and an expired pulse output. It is shared by OPEN and LOCKOUT.

Test Plan:
Bench params: DIGIT_W=4, NUM_DIGITS=4, DEFAULT_PIN=16'h1234, MAX_TRIES=3, UNLOCK_CYCLES=4, LOCKOUT_CYCLES=8, ALARM_LOCKOUTS=2.
- Correct PIN: digits 1,2,3,4 then enter -> unlocked=1 two cycles after enter, held 4 cycles, fail_cnt=0.
- Wrong PIN three times (1,2,3,5 each) -> fail_cnt 1,2,3; lockout=1 for 8 cycles; digits ignored during lockout; fail_cnt=0 after.
- Two full lockouts with no success between -> alarm=1 and stays 1 after later success; cleared only by rst.
- Unlock, chg_req, enter 9,8,7,6 twice -> chg_done pulse; then 1,2,3,4 fails and 9,8,7,6 unlocks.
- Change with confirm 9,8,7,7 -> chg_err pulse, PIN stays 16'h1234; short entry 1,2 then enter -> fail_cnt=1.
- 5 digits 1,2,3,4,5 -> entry_cnt saturates at 4, buffer 16'h1234 unlocks; clear+enter same cycle -> buffer empty, no failure counted; rst during OPEN -> unlocked=0 next cycle.
